scsi_read_latch: RTL and testbench

- Target-to-host data-in path of the BeebSCSI CPLD; the read-direction counterpart of the host-to-target write latch.
- Captures a byte that the emulated target places on the SCSI data lines during a data-in phase (IO high) and holds it for the host data-register read.
- Completes the REQ/ACK handshake towards the target once the host has read the byte.
- Sits between the SCSI-side signals (driven by the AVR) and the host bus read multiplexer.

---
 rtl/scsi_pkg.sv | 27 ++
 rtl/scsi_sync.sv | 22 ++
 rtl/scsi_read_latch.sv | 104 ++++++++++
 tb/tb_scsi_read_latch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scsi_pkg.sv
// scsi_pkg: shared FSM encoding, active-low levels and sizing helper for the
// BeebSCSI target-to-host read latch.
package scsi_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_HOST = 2'd1;
   localparam logic [1:0] ST_ACK       = 2'd2;
   localparam logic [1:0] ST_WAIT_REL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      WAIT_HOST = ST_WAIT_HOST,
      ACK       = ST_ACK,
      WAIT_REL  = ST_WAIT_REL
   } state_e;

   localparam logic ASSERTED_N = 1'b0;
   localparam logic NEGATED_N  = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/scsi_sync.sv
// scsi_sync: STAGES-deep flop chain bringing an asynchronous SCSI line into
// the CLK domain; resets to the line's inactive level.
module scsi_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
      else        sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/scsi_read_latch.sv
// scsi_read_latch: captures a target data-in byte for the host data register
// and completes the REQ/ACK handshake once the host has read it.
module scsi_read_latch
   import scsi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ACK_CYCLES  = 4
) (
   input  logic       CLK,
   input  logic       nRESET,
   input  logic [7:0] TD,
   input  logic       nREQ,
   input  logic       IO,
   input  logic       HOST_RD,
   output logic [7:0] DOUT,
   output logic       DREADY,
   output logic       nACK,
   output logic       ABORT
);

   localparam int CW = (clog2(ACK_CYCLES) < 1) ? 1 : clog2(ACK_CYCLES);

   logic          nreq_s, io_s;
   state_e        state_q, state_d;
   logic [7:0]    dout_q, dout_d;
   logic          dready_q, dready_d;
   logic          nack_q, nack_d;
   logic          abort_q, abort_d;
   logic [CW-1:0] cnt_q, cnt_d;

   scsi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nreq (
      .clk(CLK), .rst_n(nRESET), .d_i(nREQ), .q_o(nreq_s)
   );

   scsi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_io (
      .clk(CLK), .rst_n(nRESET), .d_i(IO), .q_o(io_s)
   );

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= IDLE;
         dout_q   <= 8'h00;
         dready_q <= 1'b0;
         nack_q   <= NEGATED_N;
         abort_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         dready_q <= dready_d;
         nack_q   <= nack_d;
         abort_q  <= abort_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dout_d   = dout_q;
      dready_d = dready_q;
      nack_d   = nack_q;
      abort_d  = abort_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (!nreq_s && io_s) begin
               dout_d   = TD;
               dready_d = 1'b1;
               abort_d  = 1'b0;
               state_d  = WAIT_HOST;
            end
         end
         // a host read in the same cycle as a withdrawal still completes the handshake
         WAIT_HOST: begin
            if (HOST_RD) begin
               dready_d = 1'b0;
               nack_d   = ASSERTED_N;
               cnt_d    = CW'(ACK_CYCLES - 1);
               state_d  = ACK;
            end else if (nreq_s || !io_s) begin
               dready_d = 1'b0;
               abort_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         ACK: begin
            if (cnt_q == '0) begin
               nack_d  = NEGATED_N;
               state_d = WAIT_REL;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WAIT_REL: state_d = nreq_s ? IDLE : WAIT_REL;
         default:  state_d = IDLE;
      endcase
   end

   assign DOUT   = dout_q;
   assign DREADY = dready_q;
   assign nACK   = nack_q;
   assign ABORT  = abort_q;

endmodule

// File: tb/tb_scsi_read_latch.sv
// tb_scsi_read_latch: table-driven, directed and randomized transaction-level
// checks of the read latch against a byte/flag reference model.
module tb_scsi_read_latch;

   localparam int SYNC = 2;
   localparam int ACKC = 4;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [7:0] td = 8'h00;
   logic       nreq = 1'b1;
   logic       io = 1'b0;
   logic       hrd = 1'b0;
   logic [7:0] dout;
   logic       dready, nack, abort;

   int checks = 0;
   int errors = 0;

   scsi_read_latch #(.SYNC_STAGES(SYNC), .ACK_CYCLES(ACKC)) dut (
      .CLK(clk), .nRESET(nrst), .TD(td), .nREQ(nreq), .IO(io), .HOST_RD(hrd),
      .DOUT(dout), .DREADY(dready), .nACK(nack), .ABORT(abort)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       nreq, io, rd;
      logic [7:0] td;
      logic       ex_dready, ex_nack, ex_abort;
      logic [7:0] ex_dout;
   } row_t;

   row_t tbl[20];

   logic [7:0] m_dout;
   logic       m_abort;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0; nreq = 1'b1; io = 1'b0; hrd = 1'b0;
      repeat (2) step();
      nrst = 1'b1;
      repeat (SYNC + 1) step();
      m_dout = 8'h00;
      m_abort = 1'b0;
   endtask

   task automatic capture(input logic [7:0] b);
      int n;
      td = b; io = 1'b1; nreq = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!dready && n < 20);
      chk("capture_latency", 8'(n), 8'(SYNC + 1));
      chk("capture_dout", dout, b);
      chk("capture_abort_clr", {7'd0, abort}, 8'd0);
      m_dout = b;
      m_abort = 1'b0;
   endtask

   task automatic host_read();
      int n;
      hrd = 1'b1;
      step();
      hrd = 1'b0;
      chk("read_dready_drop", {7'd0, dready}, 8'd0);
      n = (nack == 1'b0) ? 1 : 0;
      for (int i = 0; i < 20 && nack == 1'b0; i++) begin
         step();
         if (nack == 1'b0) n++;
      end
      chk("ack_width", 8'(n), 8'(ACKC));
      chk("read_dout_hold", dout, m_dout);
   endtask

   task automatic release_req();
      nreq = 1'b1; io = 1'b0;
      repeat (SYNC + 2) step();
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h11};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h11};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h11};
      tbl[19] = '{1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};

      // reset held with an active request: outputs stay at reset values
      nrst = 1'b0; nreq = 1'b0; io = 1'b1; td = 8'hA5;
      repeat (4) begin
         step();
         chk("rst_dout", dout, 8'h00);
         chk("rst_dready", {7'd0, dready}, 8'd0);
         chk("rst_nack", {7'd0, nack}, 8'd1);
         chk("rst_abort", {7'd0, abort}, 8'd0);
      end
      nrst = 1'b1;
      repeat (SYNC) begin
         step();
         chk("post_rst_early", {7'd0, dready}, 8'd0);
      end
      step();
      chk("post_rst_dready", {7'd0, dready}, 8'd1);
      chk("post_rst_dout", dout, 8'hA5);

      do_reset();
      foreach (tbl[i]) begin
         nreq = tbl[i].nreq; io = tbl[i].io; hrd = tbl[i].rd; td = tbl[i].td;
         step();
         hrd = 1'b0;
         chk($sformatf("tbl%0d_dready", i), {7'd0, dready}, {7'd0, tbl[i].ex_dready});
         chk($sformatf("tbl%0d_nack", i), {7'd0, nack}, {7'd0, tbl[i].ex_nack});
         chk($sformatf("tbl%0d_abort", i), {7'd0, abort}, {7'd0, tbl[i].ex_abort});
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ex_dout);
      end

      // target withdraws before the host reads
      do_reset();
      capture(8'h5A);
      nreq = 1'b1;
      repeat (SYNC + 2) begin
         step();
         chk("abort_no_ack", {7'd0, nack}, 8'd1);
      end
      chk("abort_dready", {7'd0, dready}, 8'd0);
      chk("abort_flag", {7'd0, abort}, 8'd1);
      chk("abort_dout", dout, 8'h5A);
      capture(8'h77);
      host_read();
      release_req();

      // wrong phase is ignored
      td = 8'hEE; io = 1'b0; nreq = 1'b0;
      repeat (6) begin
         step();
         chk("wrong_phase_dready", {7'd0, dready}, 8'd0);
      end
      chk("wrong_phase_dout", dout, 8'h77);
      release_req();

      // host read in the same cycle the IO withdrawal is seen
      capture(8'h99);
      io = 1'b0;
      repeat (SYNC) step();
      host_read();
      chk("collision_abort", {7'd0, abort}, 8'd0);
      release_req();
      hrd = 1'b1;
      step();
      hrd = 1'b0;
      chk("idle_rd_dready", {7'd0, dready}, 8'd0);
      chk("idle_rd_nack", {7'd0, nack}, 8'd1);
      chk("idle_rd_dout", dout, 8'h99);

      // reset during the second ACK cycle
      capture(8'h42);
      hrd = 1'b1;
      step();
      hrd = 1'b0;
      step();
      chk("mid_ack_low", {7'd0, nack}, 8'd0);
      nrst = 1'b0; nreq = 1'b1; io = 1'b0;
      #1;
      chk("mid_rst_nack", {7'd0, nack}, 8'd1);
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_dready", {7'd0, dready}, 8'd0);
      repeat (2) step();
      nrst = 1'b1;
      repeat (8) begin
         step();
         chk("post_mid_rst_nack", {7'd0, nack}, 8'd1);
      end

      // randomized transactions against the byte/flag model
      do_reset();
      for (int t = 0; t < 40; t++) begin
         int kind, d;
         logic [7:0] b;
         kind = int'($urandom_range(0, 2));
         d = int'($urandom_range(0, 5));
         b = 8'($urandom);
         if (kind == 2) begin
            td = b; io = 1'b0; nreq = 1'b0;
            repeat (5) step();
            chk("rnd_wp_dready", {7'd0, dready}, 8'd0);
            chk("rnd_wp_dout", dout, m_dout);
            chk("rnd_wp_abort", {7'd0, abort}, {7'd0, m_abort});
         end else begin
            capture(b);
            repeat (d) begin
               step();
               chk("rnd_hold_dready", {7'd0, dready}, 8'd1);
               chk("rnd_hold_nack", {7'd0, nack}, 8'd1);
            end
            if (kind == 0) begin
               host_read();
               chk("rnd_read_abort", {7'd0, abort}, 8'd0);
            end else begin
               if ($urandom_range(0, 1) == 1) nreq = 1'b1;
               else io = 1'b0;
               repeat (SYNC + 2) begin
                  step();
                  chk("rnd_abort_nack", {7'd0, nack}, 8'd1);
               end
               m_abort = 1'b1;
               chk("rnd_abort_flag", {7'd0, abort}, {7'd0, m_abort});
               chk("rnd_abort_dready", {7'd0, dready}, 8'd0);
               chk("rnd_abort_dout", dout, m_dout);
            end
         end
         release_req();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
